// File: rtl/lcms_adc_readout_pkg.sv
// Shared definitions for the serial-ADC readout: FSM state encoding and default geometry.
package lcms_adc_readout_pkg;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_CNV_HIGH    = 2;
    localparam int unsigned DEF_CONV_CYCLES = 14;
    localparam int unsigned DEF_OVR_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CNV   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } adc_state_e;

endpackage

// File: rtl/lcms_adc_readout_shift_rx.sv
// Serial receive shift register with a bit counter; captures MSB-first into the LSB.
module lcms_adc_shift_rx
    import lcms_adc_readout_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              adc_sm_clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              shift_en_i,
    input  logic              sdo_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);

    localparam int unsigned BC_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;

    always_comb begin
        sreg_d = sreg_q;
        bcnt_d = bcnt_q;
        if (shift_en_i) begin
            sreg_d = {sreg_q[DATA_W-2:0], sdo_i};
            if (bcnt_q != '0) begin
                bcnt_d = bcnt_q - BC_W'(1);
            end
        end else if (load_i) begin
            bcnt_d = BC_W'(DATA_W);
        end
    end

    always_ff @(posedge adc_sm_clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= '0;
            bcnt_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign data_o = sreg_q;
    assign done_o = (bcnt_q == '0);

endmodule

// File: rtl/lcms_adc_readout.sv
// Serial-ADC front end: CNV pulse, conversion wait, MSB-first SCK readout, overrun tracking.
// Define ADC_TEST_PATTERN_EN to replace the sampled word with an incrementing test pattern.
module lcms_adc_readout
    import lcms_adc_readout_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CNV_HIGH    = DEF_CNV_HIGH,
    parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int unsigned OVR_W       = DEF_OVR_W
) (
    input  logic              adc_sm_clk,
    input  logic              reset_n,
    input  logic              conv_req,
    input  logic              clr_ovr,
    input  logic              ADC_SDO,
    output logic              ADC_CNV,
    output logic              ADC_SCK,
    output logic              ADC_SDI,
    output logic [DATA_W-1:0] adc_result,
    output logic              result_valid,
    output logic              busy,
    output logic              overrun,
    output logic [OVR_W-1:0]  overrun_cnt
);

    localparam int unsigned CYC_MAX = (CNV_HIGH > CONV_CYCLES) ? CNV_HIGH : CONV_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    adc_state_e        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              cnv_q, cnv_d;
    logic              sck_q, sck_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              rx_load, rx_shift, rx_done;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] sample;

    lcms_adc_shift_rx #(
        .DATA_W(DATA_W)
    ) u_shift_rx (
        .adc_sm_clk(adc_sm_clk),
        .reset_n   (reset_n),
        .load_i    (rx_load),
        .shift_en_i(rx_shift),
        .sdo_i     (ADC_SDO),
        .data_o    (rx_data),
        .done_o    (rx_done)
    );

`ifdef ADC_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_q;

    always_ff @(posedge adc_sm_clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
        end else if (valid_d) begin
            pat_q <= pat_q + DATA_W'(1);
        end
    end

    assign sample = pat_q;
`else
    assign sample = rx_data;
`endif

    // The WAIT->SHIFT edge already raises SCK and takes the first (MSB) capture.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        cnv_d    = cnv_q;
        sck_d    = sck_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        result_d = result_q;
        rx_load  = 1'b0;
        rx_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (conv_req) begin
                    state_d = ST_CNV;
                    cyc_d   = CYC_W'(CNV_HIGH - 1);
                    cnv_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_CNV: begin
                if (cyc_q == '0) begin
                    state_d = ST_WAIT;
                    cyc_d   = CYC_W'(CONV_CYCLES - 1);
                    cnv_d   = 1'b0;
                    rx_load = 1'b1;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            ST_WAIT: begin
                if (cyc_q == '0) begin
                    state_d  = ST_SHIFT;
                    sck_d    = 1'b1;
                    rx_shift = 1'b1;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sck_q) begin
                    sck_d = 1'b0;
                end else if (rx_done) begin
                    state_d  = ST_DONE;
                    valid_d  = 1'b1;
                    result_d = sample;
                end else begin
                    sck_d    = 1'b1;
                    rx_shift = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cnv_d   = 1'b0;
                sck_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        ovr_d     = ovr_q;
        ovr_cnt_d = ovr_cnt_q;
        if (clr_ovr) begin
            ovr_d     = 1'b0;
            ovr_cnt_d = '0;
        end else if (conv_req && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
            if (ovr_cnt_q != '1) begin
                ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
            end
        end
    end

    always_ff @(posedge adc_sm_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            cnv_q     <= 1'b0;
            sck_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            cnv_q     <= cnv_d;
            sck_q     <= sck_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
            result_q  <= result_d;
        end
    end

    assign ADC_CNV      = cnv_q;
    assign ADC_SCK      = sck_q;
    assign ADC_SDI      = 1'b1;
    assign adc_result   = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;
    assign overrun_cnt  = ovr_cnt_q;

endmodule
